// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port 1024x16 data RAM between port A (instruction fetch)
//   and port B (load/store). The winning request is latched in IDLE and held
//   on the RAM pins for one ACCESS cycle. Read data is captured at the end of
//   ACCESS. The winner gets a one-cycle ack during DONE.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata      port A request (held until a_ack)
//   a_ack, a_rdata                 port A completion pulse and read data
//   b_req/b_we/b_addr/b_wdata      port B request
//   b_ack, b_rdata                 port B completion pulse and read data
//   ram_write_n/ram_addr/ram_data_in  RAM control, address and write data
//   ram_data_out                   RAM combinational read data
//   busy                           high whenever an access is in flight
module ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_write_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic PRI_A = (FIXED_PRI != 0);

  state_t state;
  logic   last_grant_b;
  logic   win_b;
  logic   grant_a;

  // A wins when it requests and either B is idle, A has fixed priority, or B
  // had the previous grant. Only consulted in IDLE, so it never reaches an
  // output without passing through a register.
  assign grant_a = a_req & (~b_req | PRI_A | last_grant_b);

  assign busy = (state != IDLE);

  // Sequencer. IDLE latches the winner onto the RAM pins. ACCESS holds them
  // for one cycle, while the RAM commits a write or the read data is captured.
  // DONE is the cycle in which the winner's ack is visible. Reset leaves
  // last_grant on B so that A takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ram_write_n  <= 1'b1;
      ram_addr     <= '0;
      ram_data_in  <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      last_grant_b <= 1'b1;
      win_b        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (a_req || b_req) begin
            win_b        <= ~grant_a;
            last_grant_b <= ~grant_a;
            ram_addr     <= grant_a ? a_addr : b_addr;
            ram_data_in  <= grant_a ? a_wdata : b_wdata;
            ram_write_n  <= grant_a ? ~a_we : ~b_we;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // ram_write_n still holds the latched direction here: high means a read.
          if (ram_write_n) begin
            if (win_b) b_rdata <= ram_data_out;
            else       a_rdata <= ram_data_out;
          end
          ram_write_n <= 1'b1;
          a_ack       <= ~win_b;
          b_ack       <= win_b;
          state       <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_write_n <= 1'b1;
          a_ack       <= 1'b0;
          b_ack       <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
